// File: rtl/spi_flash_arbiter.sv
// Two-master SPI flash arbiter: round-robin grant, guard gap, idle timeout.
// Flash pins are registered; miso is returned combinationally to the owner.
module spi_flash_arbiter #(
    parameter int unsigned GUARD_CYCLES   = 4,
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned CNT_W          = 16
) (
    input  logic clk_48mhz,
    input  logic reset_n,
    input  logic a_req,
    output logic a_gnt,
    input  logic a_sck,
    input  logic a_cs,
    input  logic a_mosi,
    output logic a_miso,
    input  logic b_req,
    output logic b_gnt,
    input  logic b_sck,
    input  logic b_cs,
    input  logic b_mosi,
    output logic b_miso,
    output logic flash_sck,
    output logic flash_csn,
    output logic flash_mosi,
    input  logic flash_miso,
    output logic busy,
    output logic timeout_pulse
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OWN_A = 2'd1,
        OWN_B = 2'd2,
        GUARD = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] GUARD_LD = CNT_W'(GUARD_CYCLES);
    localparam logic [CNT_W-1:0] TO_LAST  =
        CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);
    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);

    state_t           state_q, state_d;
    logic             last_b_q, last_b_d;
    logic [CNT_W-1:0] to_q, to_d;
    logic [CNT_W-1:0] grd_q, grd_d;
    logic             a_mask_q, a_mask_d;
    logic             b_mask_q, b_mask_d;
    logic             csn_q, csn_d;
    logic             sck_q, sck_d;
    logic             mosi_q, mosi_d;
    logic             tp_q, tp_d;

    logic own_act, own_req, own_cs, own_sck, own_mosi;
    logic a_eff, b_eff, to_hit;

    assign a_eff = a_req & ~a_mask_q;
    assign b_eff = b_req & ~b_mask_q;

    // Select the current owner's pins; idle values when nobody owns.
    always_comb begin
        own_act  = 1'b0;
        own_req  = 1'b0;
        own_cs   = 1'b1;
        own_sck  = 1'b0;
        own_mosi = 1'b0;
        if (state_q == OWN_A) begin
            own_act  = 1'b1;
            own_req  = a_req;
            own_cs   = a_cs;
            own_sck  = a_sck;
            own_mosi = a_mosi;
        end else if (state_q == OWN_B) begin
            own_act  = 1'b1;
            own_req  = b_req;
            own_cs   = b_cs;
            own_sck  = b_sck;
            own_mosi = b_mosi;
        end
    end

    // State and round-robin pointer; reset hands A the first tie.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            last_b_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            last_b_q <= last_b_d;
        end
    end

    // Next state: grant, frame-safe release, timeout revoke, guard exit.
    always_comb begin
        state_d  = state_q;
        last_b_d = last_b_q;
        to_hit   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (a_eff && (!b_eff || last_b_q)) begin
                    state_d = OWN_A;
                end else if (b_eff) begin
                    state_d = OWN_B;
                end
            end
            OWN_A, OWN_B: begin
                if (own_cs && !own_req) begin
                    state_d  = GUARD;
                    last_b_d = (state_q == OWN_B);
                end else if (TO_EN && own_cs && to_q == TO_LAST) begin
                    state_d  = GUARD;
                    last_b_d = (state_q == OWN_B);
                    to_hit   = 1'b1;
                end
            end
            GUARD: begin
                if (grd_q <= ONE) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Grants, busy and miso return decode from the registered state.
    always_comb begin
        a_gnt  = (state_q == OWN_A);
        b_gnt  = (state_q == OWN_B);
        busy   = (state_q != IDLE);
        a_miso = (state_q == OWN_A) & flash_miso;
        b_miso = (state_q == OWN_B) & flash_miso;
    end

    // Counters, revoke masks and pin register next values.
    always_comb begin
        to_d = '0;
        if (own_act && own_cs) begin
            to_d = (to_q != '1) ? to_q + ONE : to_q;
        end

        grd_d = grd_q;
        if (state_d == GUARD && state_q != GUARD) begin
            grd_d = GUARD_LD;
        end else if (state_q == GUARD && grd_q != '0) begin
            grd_d = grd_q - ONE;
        end

        a_mask_d = a_req & (a_mask_q | (to_hit & (state_q == OWN_A)));
        b_mask_d = b_req & (b_mask_q | (to_hit & (state_q == OWN_B)));

        csn_d  = own_cs;
        sck_d  = own_sck;
        mosi_d = own_mosi;
        tp_d   = to_hit;
    end

    // Datapath registers; csn returns high at once on reset.
    always_ff @(posedge clk_48mhz or negedge reset_n) begin
        if (!reset_n) begin
            to_q     <= '0;
            grd_q    <= '0;
            a_mask_q <= 1'b0;
            b_mask_q <= 1'b0;
            csn_q    <= 1'b1;
            sck_q    <= 1'b0;
            mosi_q   <= 1'b0;
            tp_q     <= 1'b0;
        end else begin
            to_q     <= to_d;
            grd_q    <= grd_d;
            a_mask_q <= a_mask_d;
            b_mask_q <= b_mask_d;
            csn_q    <= csn_d;
            sck_q    <= sck_d;
            mosi_q   <= mosi_d;
            tp_q     <= tp_d;
        end
    end

    assign flash_csn     = csn_q;
    assign flash_sck     = sck_q;
    assign flash_mosi    = mosi_q;
    assign timeout_pulse = tp_q;

endmodule
